// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM state encodings,
// DIV/DIVU aluop codes, the zero result word and a two's-complement helper.
package hilo_div_ctrl_pkg;

  localparam int DATA_W = 32;

  // Divider sequencer states
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // EX-stage aluop codes that select this unit
  localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

  // Result value when idle, aborted or dividing by zero
  localparam logic [63:0] ZERO_WORD = 64'h0;

  // Counter value on the 32nd (final) quotient step
  localparam logic [5:0] LAST_STEP = 6'd31;

  // Two's-complement negate of a 32-bit word
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the 65-bit working register left by
// one, trial-subtract the divisor from the upper 33 bits, and either keep
// the difference (quotient bit 1) or restore (quotient bit 0).
module div_step (
  input  logic [64:0] work,
  input  logic [31:0] divisor,
  output logic [64:0] next
);

  logic [64:0] shifted;
  logic [32:0] diff;

  // Compare/subtract on the partial remainder; bit 32 of diff is the borrow
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    shifted = work << 1;
    diff    = shifted[64:32] - {1'b0, divisor};
    if (!diff[32]) begin
      next = {diff, shifted[31:1], 1'b1};
    end else begin
      next = shifted;
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the HI/LO register pair.
// Runs a 32-step restoring division, stalls EX while busy and presents
// {remainder, quotient} on result_o with ready_o in the END state.
// Build option: define HILO_DIV_SIGNED_EN to honour signed_i (DIV);
// without it every operation is DIVU and signed_i is ignored.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o
);

  div_state_e  state_q;
  logic [64:0] work_q;
  logic [31:0] divisor_q;
  logic [5:0]  count_q;
  logic [64:0] next_work;

  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

`ifdef HILO_DIV_SIGNED_EN
  logic        sign_dividend_q;
  logic        sign_diff_q;
  logic        dividend_neg;
  logic        divisor_neg;
`else
  logic        unused_signed;
  assign unused_signed = signed_i;
`endif

  div_step u_div_step (
    .work    (work_q),
    .divisor (divisor_q),
    .next    (next_work)
  );

  // Operand magnitudes at start and sign fix-up of the final step's result
  always_comb begin
`ifdef HILO_DIV_SIGNED_EN
    dividend_neg = signed_i & opdata1_i[31];
    divisor_neg  = signed_i & opdata2_i[31];
    dividend_mag = dividend_neg ? neg32(opdata1_i) : opdata1_i;
    divisor_mag  = divisor_neg  ? neg32(opdata2_i) : opdata2_i;
    quot_fix     = sign_diff_q     ? neg32(next_work[31:0])  : next_work[31:0];
    rem_fix      = sign_dividend_q ? neg32(next_work[63:32]) : next_work[63:32];
`else
    dividend_mag = opdata1_i;
    divisor_mag  = opdata2_i;
    quot_fix     = next_work[31:0];
    rem_fix      = next_work[63:32];
`endif
  end

  // Stall EX while a divide is requested and its result is not yet presented
  assign stall_o = rst & start_i & ~annul_i & (state_q != DIV_END);

  // Sequencer FSM with registered result/ready outputs
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q         <= DIV_FREE;
      work_q          <= '0;
      divisor_q       <= '0;
      count_q         <= '0;
      result_o        <= ZERO_WORD;
      ready_o         <= 1'b0;
`ifdef HILO_DIV_SIGNED_EN
      sign_dividend_q <= 1'b0;
      sign_diff_q     <= 1'b0;
`endif
    end else if (annul_i) begin
      state_q  <= DIV_FREE;
      count_q  <= '0;
      result_o <= ZERO_WORD;
      ready_o  <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_FREE: begin
          if (start_i) begin
            if (opdata2_i == 32'd0) begin
              state_q <= DIV_BY_ZERO;
            end else begin
              state_q         <= DIV_ON;
              work_q          <= {33'b0, dividend_mag};
              divisor_q       <= divisor_mag;
              count_q         <= '0;
`ifdef HILO_DIV_SIGNED_EN
              sign_dividend_q <= dividend_neg;
              sign_diff_q     <= dividend_neg ^ divisor_neg;
`endif
            end
          end
        end
        DIV_BY_ZERO: begin
          state_q  <= DIV_END;
          result_o <= ZERO_WORD;
          ready_o  <= 1'b1;
        end
        DIV_ON: begin
          work_q  <= next_work;
          count_q <= count_q + 6'd1;
          if (count_q == LAST_STEP) begin
            state_q  <= DIV_END;
            result_o <= {rem_fix, quot_fix};
            ready_o  <= 1'b1;
          end
        end
        DIV_END: begin
          if (!start_i) begin
            state_q  <= DIV_FREE;
            result_o <= ZERO_WORD;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: directed cases, annul, reset
// mid-operation and randomized divides against an arithmetic reference.
// Honours HILO_DIV_SIGNED_EN the same way the design does.
module tb_hilo_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int n_cmp;
  int n_bad;

  hilo_div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero when signed
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'h0;
`ifdef HILO_DIV_SIGNED_EN
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
`endif
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  function automatic int ref_latency(input logic [31:0] b);
    return (b == 32'd0) ? 2 : 33;
  endfunction

  // Drive one divide starting now (caller is at a negedge). Returns the
  // ready cycle (-1 on timeout), stall cycles seen, the result, whether the
  // result held for a cycle with start still high (and stall low in END),
  // and whether outputs cleared after start dropped.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int lat, output int stall_cnt, output logic [63:0] res,
                         output logic held_ok, output logic cleared_ok);
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    lat       = -1;
    stall_cnt = 0;
    held_ok   = 1'b0;
    cleared_ok = 1'b0;
    res       = 64'hx;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (ready_o) begin
        lat = c;
        break;
      end
      if (stall_o) stall_cnt++;
      @(negedge clk);
      if (c == 0) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~sgn;
      end
    end
    if (lat < 0) begin
      start_i = 1'b0;
      return;
    end
    res     = result_o;
    held_ok = !stall_o;
    @(negedge clk);
    #1;
    held_ok = held_ok && ready_o && (result_o === res) && !stall_o;
    start_i = 1'b0;
    @(negedge clk);
    #1;
    cleared_ok = !ready_o && (result_o === 64'h0) && !stall_o;
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    annul_i   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({ready_o, stall_o, result_o} !== 66'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b stall=%b result=%h, want all zero",
               ready_o, stall_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({ready_o, stall_o, result_o} !== 66'h0) begin
      n_bad++;
      $display("FAIL post_reset_idle: ready=%b stall=%b result=%h, want all zero",
               ready_o, stall_o, result_o);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  task automatic test_directed;
    vec_t vecs[5];
    int lat, stall_cnt;
    logic [63:0] res;
    logic held_ok, cleared_ok;
    vecs[0] = '{"divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}};
`ifdef HILO_DIV_SIGNED_EN
    vecs[1] = '{"div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[2] = '{"div_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}};
`else
    vecs[1] = '{"div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'h1, 32'h7FFF_FFFC}};
    vecs[2] = '{"div_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0}};
`endif
    vecs[3] = '{"divu_5_0", 32'd5, 32'd0, 1'b0, 64'h0};
    vecs[4] = '{"divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}};
    foreach (vecs[i]) begin
      @(negedge clk);
      run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, lat, stall_cnt, res, held_ok, cleared_ok);
      n_cmp++;
      if (lat !== ref_latency(vecs[i].b)) begin
        n_bad++;
        $display("FAIL %s latency: got %0d want %0d", vecs[i].name, lat, ref_latency(vecs[i].b));
      end
      n_cmp++;
      if (stall_cnt !== ref_latency(vecs[i].b)) begin
        n_bad++;
        $display("FAIL %s stall_cycles: got %0d want %0d", vecs[i].name, stall_cnt,
                 ref_latency(vecs[i].b));
      end
      n_cmp++;
      if (res !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL %s result: got %h want %h", vecs[i].name, res, vecs[i].exp);
      end
      n_cmp++;
      if ({held_ok, cleared_ok} !== 2'b11) begin
        n_bad++;
        $display("FAIL %s hold_clear: got held=%b cleared=%b want 1 1", vecs[i].name,
                 held_ok, cleared_ok);
      end
    end
  endtask

  task automatic test_annul;
    int lat, stall_cnt;
    logic [63:0] res;
    logic held_ok, cleared_ok;
    logic saw_ready;
    saw_ready = 1'b0;
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ready_o) saw_ready = 1'b1;
      @(negedge clk);
    end
    annul_i = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_bad++;
      $display("FAIL annul_stall: got %b want 0", stall_o);
    end
    @(negedge clk);
    #1;
    if (ready_o) saw_ready = 1'b1;
    n_cmp++;
    if ({saw_ready, result_o} !== 65'h0) begin
      n_bad++;
      $display("FAIL annul_abort: saw_ready=%b result=%h want 0 0", saw_ready, result_o);
    end
    annul_i = 1'b0;
    run_div(32'd100, 32'd7, 1'b0, lat, stall_cnt, res, held_ok, cleared_ok);
    n_cmp++;
    if (lat !== 33) begin
      n_bad++;
      $display("FAIL annul_restart latency: got %0d want 33", lat);
    end
    n_cmp++;
    if (res !== {32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL annul_restart result: got %h want %h", res, {32'd2, 32'd14});
    end
  endtask

  task automatic test_reset_mid;
    int lat, stall_cnt;
    logic [63:0] res;
    logic held_ok, cleared_ok;
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({ready_o, stall_o, result_o} !== 66'h0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: ready=%b stall=%b result=%h want all zero",
               ready_o, stall_o, result_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div(32'd9, 32'd3, 1'b0, lat, stall_cnt, res, held_ok, cleared_ok);
    n_cmp++;
    if (lat !== 33) begin
      n_bad++;
      $display("FAIL reset_mid_restart latency: got %0d want 33", lat);
    end
    n_cmp++;
    if (res !== {32'd0, 32'd3}) begin
      n_bad++;
      $display("FAIL reset_mid_restart result: got %h want %h", res, {32'd0, 32'd3});
    end
  endtask

  task automatic test_random;
    int lat, stall_cnt;
    logic [63:0] res, exp;
    logic held_ok, cleared_ok;
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      if (i % 6 == 5) a = 32'h8000_0000;
      exp = ref_div(a, b, sgn);
      @(negedge clk);
      run_div(a, b, sgn, lat, stall_cnt, res, held_ok, cleared_ok);
      n_cmp++;
      if (lat !== ref_latency(b) || stall_cnt !== ref_latency(b)) begin
        n_bad++;
        $display("FAIL rand%0d timing: got lat=%0d stall=%0d want %0d", i, lat, stall_cnt,
                 ref_latency(b));
      end
      n_cmp++;
      if (res !== exp) begin
        n_bad++;
        $display("FAIL rand%0d result (%h/%h s=%b): got %h want %h", i, a, b, sgn, res, exp);
      end
      n_cmp++;
      if ({held_ok, cleared_ok} !== 2'b11) begin
        n_bad++;
        $display("FAIL rand%0d hold_clear: got held=%b cleared=%b want 1 1", i, held_ok,
                 cleared_ok);
      end
    end
  endtask

  // Back-to-back: restart on the first idle cycle after END
  task automatic test_back_to_back;
    int lat, stall_cnt;
    logic [63:0] res;
    logic held_ok, cleared_ok;
    @(negedge clk);
    run_div(32'd1000, 32'd10, 1'b0, lat, stall_cnt, res, held_ok, cleared_ok);
    run_div(32'd77, 32'd5, 1'b0, lat, stall_cnt, res, held_ok, cleared_ok);
    n_cmp++;
    if (lat !== 33 || res !== {32'd2, 32'd15}) begin
      n_bad++;
      $display("FAIL back_to_back: got lat=%0d result=%h want 33 %h", lat, res,
               {32'd2, 32'd15});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
